// File: rtl/csm_nport_mem.sv
// N-port shared memory with per-address hold/release locks.
// One request per cycle is granted round robin; its response follows one cycle later.
module csm_nport_mem #(
    parameter int NPORTS = 2,
    parameter int AW     = 3,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req_valid,
    input  logic [2*NPORTS-1:0]  req_op,
    input  logic [AW*NPORTS-1:0] req_addr,
    input  logic [DW*NPORTS-1:0] req_wdata,
    output logic [NPORTS-1:0]    req_ready,
    output logic [NPORTS-1:0]    rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic [AW:0]          lock_cnt
);
    localparam int DEPTH = 2 ** AW;
    localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_HOLD    = 2'b10,
        OP_RELEASE = 2'b11
    } op_e;

    logic [DW-1:0]     mem_q        [DEPTH];
    logic              lock_held_q  [DEPTH];
    logic [PW-1:0]     lock_owner_q [DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [AW:0]       lock_cnt_q, lock_cnt_d;
    logic [NPORTS-1:0] rsp_valid_q;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NPORTS) sum = sum - NPORTS;
        return PW'(sum);
    endfunction

    logic          grant_any;
    logic [PW-1:0] grant_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        grant_any = 1'b0;
        grant_idx = ptr_q;
        for (int k = 0; k < NPORTS; k++) begin
            if (!grant_any && req_valid[wrap_idx(ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(ptr_q, k);
            end
        end
    end

    assign req_ready = (grant_any && !reset) ? (NPORTS'(1) << grant_idx) : '0;

    op_e           sel_op;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign sel_op    = op_e'(req_op[2*int'(grant_idx) +: 2]);
    assign sel_addr  = req_addr[AW*int'(grant_idx) +: AW];
    assign sel_wdata = req_wdata[DW*int'(grant_idx) +: DW];

    logic held, owned, foreign;
    logic mem_we, lock_set, lock_clr;

    always_comb begin
        held       = lock_held_q[sel_addr];
        owned      = held && (lock_owner_q[sel_addr] == grant_idx);
        foreign    = held && !owned;
        mem_we     = 1'b0;
        lock_set   = 1'b0;
        lock_clr   = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
        if (grant_any) begin
            case (sel_op)
                OP_READ: begin
                    rsp_err_d = foreign;
                    if (!foreign) rsp_data_d = mem_q[sel_addr];
                end
                OP_WRITE: begin
                    rsp_err_d = foreign;
                    mem_we    = !foreign;
                end
                OP_HOLD: begin
                    // Re-holding an address already owned succeeds without touching the count.
                    rsp_err_d = foreign;
                    lock_set  = !held;
                end
                OP_RELEASE: begin
                    rsp_err_d = !owned;
                    lock_clr  = owned;
                end
                default: ;
            endcase
        end
        ptr_d      = grant_any ? wrap_idx(grant_idx, 1) : ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (lock_set)      lock_cnt_d = lock_cnt_q + (AW+1)'(1);
        else if (lock_clr) lock_cnt_d = lock_cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: reset must leave every word and lock cleared, so the arrays are built from resettable flops.
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a]        <= '0;
                lock_held_q[a]  <= 1'b0;
                lock_owner_q[a] <= '0;
            end
            ptr_q       <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all state update together at the edge, independent of statement order.
            ptr_q       <= ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= req_ready;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            if (mem_we) mem_q[sel_addr] <= sel_wdata;
            if (lock_set) begin
                lock_held_q[sel_addr]  <= 1'b1;
                lock_owner_q[sel_addr] <= grant_idx;
            end else if (lock_clr) begin
                lock_held_q[sel_addr]  <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign lock_cnt  = lock_cnt_q;

endmodule
